// File: rtl/grf_write_arbiter_pkg.sv
// Shared CPU definitions for the register-file write side.
// Register/data widths and the queued MD result record.
package grf_write_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 1 << REG_AW;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } md_entry_t;

  function automatic logic [NREG-1:0] reg_onehot(
    input logic [REG_AW-1:0] a
  );
    logic [NREG-1:0] r;
    r    = '0;
    r[a] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/grf_write_arbiter_wq.sv
// MD result queue: circular buffer with per-entry kill by address
// and a registered mask of registers that still have a live write.
module grf_wq_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  md_entry_t             push_e_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  logic [REG_AW-1:0]     kill_addr_i,
  output md_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic [NREG-1:0]       mask_o
);

  md_entry_t       mem_q [DEPTH];
  md_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0] pend_q, pend_d;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && mem_q[i].addr == kill_addr_i) begin
        mem_d[i].live = 1'b0;
      end
    end
    // Popped slots are cleared so only occupied slots can be live.
    if (pop_i) begin
      mem_d[rd_q].live = 1'b0;
      rd_d             = ptr_inc(rd_q);
    end
    if (push_i) begin
      mem_d[wr_q] = push_e_i;
      wr_d        = ptr_inc(wr_q);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_d[i].live) begin
        pend_d = pend_d | reg_onehot(mem_d[i].addr);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign mask_o  = pend_q;

endmodule

// File: rtl/grf_write_arbiter.sv
// Register-file write port arbiter: pipeline WB passes straight
// through, MD results queue up and drain into idle port cycles.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_AW-1:0] md_addr,
  input  logic [DATA_W-1:0] md_data,
  input  logic [DATA_W-1:0] md_pc,
  output logic              grf_we,
  output logic [REG_AW-1:0] grf_addr,
  output logic [DATA_W-1:0] grf_wd,
  output logic [DATA_W-1:0] grf_pc,
  output logic [NREG-1:0]   pend_mask
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            wb_wr;
  logic            q_nempty;
  logic            head_live;
  logic            push;
  logic            pop;
  logic [CW-1:0]   cnt;
  md_entry_t       head;
  md_entry_t       push_e;

  assign wb_wr     = wb_we && (wb_addr != REG_ZERO);
  assign q_nempty  = (cnt != '0);
  assign head_live = q_nempty && head.live;

  assign md_ready = !reset && (cnt < CW'(DEPTH));
  assign push     = md_valid && md_ready && (md_addr != REG_ZERO);
  // A live head yields to the pipeline; a dead one is dropped anyway.
  assign pop      = q_nempty && (!wb_wr || !head.live);

  always_comb begin
    push_e      = '0;
    push_e.live = !(wb_wr && (wb_addr == md_addr));
    push_e.addr = md_addr;
    push_e.data = md_data;
    push_e.pc   = md_pc;
  end

  grf_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_wq (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_e_i    (push_e),
    .pop_i       (pop),
    .kill_i      (wb_wr),
    .kill_addr_i (wb_addr),
    .head_o      (head),
    .count_o     (cnt),
    .mask_o      (pend_mask)
  );

  always_comb begin
    grf_we   = 1'b0;
    grf_addr = '0;
    grf_wd   = '0;
    grf_pc   = '0;
    priority case (1'b1)
      reset: begin
        grf_we = 1'b0;
      end
      wb_wr: begin
        grf_we   = 1'b1;
        grf_addr = wb_addr;
        grf_wd   = wb_data;
        grf_pc   = wb_pc;
      end
      head_live: begin
        grf_we   = 1'b1;
        grf_addr = head.addr;
        grf_wd   = head.data;
        grf_pc   = head.pc;
      end
      default: begin
        grf_we = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/grf_write_arbiter.md
# grf_write_arbiter

Write-side controller for the general register file. Merges two writeback sources onto the register file's single write port: the in-order pipeline WB stage and the long-latency multiply/divide unit. Pipeline WB writes pass through in the same cycle. MD results are buffered in a small queue and drained into idle write-port cycles. A per-register pending mask drives the hazard/stall logic.

## Interface
Parameters:
- `DEPTH`, default 2: MD result queue entries; must be ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `wb_we`  in  1  pipeline WB write enable.
- `wb_addr`  in  5  pipeline WB destination register.
- `wb_data`  in  32  pipeline WB write data.
- `wb_pc`  in  32  PC of the WB instruction.
- `md_valid`  in  1  MD result offered.
- `md_ready`  out  1  queue can accept an MD result.
- `md_addr`  in  5  MD destination register.
- `md_data`  in  32  MD result data.
- `md_pc`  in  32  PC of the MD-issuing instruction.
- `grf_we`  out  1  register file write enable.
- `grf_addr`  out  5  register file write address.
- `grf_wd`  out  32  register file write data.
- `grf_pc`  out  32  PC of the write, for trace.
- `pend_mask`  out  32  bit i set while a live queued write targets register i.

## Operation
- A **pipeline write** is `wb_we && wb_addr!=0`. It always owns the port in its own cycle. `grf_*` follow `wb_*` combinationally.
- **MD accept** (push) happens at an edge where `md_valid && md_ready`.
  - If `md_addr==0`, the result is accepted and discarded: no enqueue, no mask bit.
- **Queue entries** hold {live, addr, data, pc}, in FIFO order.
- **Kill rule:** when a pipeline write to register X commits, every queued entry with addr X has live cleared.
  - This includes an entry being pushed in the same cycle with `md_addr==X`.
  - The pipeline value always wins.
- **Pop:** the head is popped at an edge when the queue is non-empty and either no pipeline write is present or the head is dead.
  - A live head popped with no pipeline write drives `grf_we=1` with the head's addr, data and pc.
  - A dead head is discarded with no write. It may pop in the same cycle as a pipeline write.
- **When neither source writes:** `grf_we=0`, and `grf_addr`, `grf_wd`, `grf_pc` are 0.
- **`pend_mask`** is the OR over live entries of the one-hot addr. It is registered state, updated at the same edge as push, pop and kill.
- **`md_ready`** is `count<DEPTH`, from registered count only.
  - When full, `md_ready=0` even if a pop occurs that cycle.
- **Simultaneous push and pop** is legal. `count` is unchanged.

## Timing
- **Pipeline write latency:** 0 cycles to `grf_*`; the register file commits at the next edge.
- **MD latency:** a result pushed at edge E is presented on `grf_*` in cycle E..E+1 at the earliest, and committed at edge E+1.
  - There is no combinational path from `md_*` to `grf_*`.
- **Starvation:** MD results wait while the pipeline writes every cycle. The queue fills and `md_ready` drops; the MD unit must hold `md_valid` and its data.
- **Reset (async, any time):**
  - Queue is emptied, count=0.
  - `pend_mask=0`.
  - `md_ready=0` while reset is asserted, 1 after release.
  - `grf_we=0` is forced while reset is asserted.
  - An in-flight MD handshake is lost.
- **Width rules:**
  - count is `$clog2(DEPTH+1)` bits.
  - Pointers are `$clog2(DEPTH)` bits (minimum 1) and wrap modulo DEPTH.

## Structure
- Shared CPU package holds:
  - `REG_AW=5` and `DATA_W=32`.
  - `REG_ZERO=5'd0`.
  - The `md_entry_t` typedef {live, addr, data, pc}.
- Sub-module `grf_wq_fifo`: circular buffer with push, pop, per-entry address-match kill, head output, count, and live-mask generation.
- Top level: source select and port muxing.

## Test plan
- **Pipeline passthrough:** `wb_we=1`, `wb_addr=8`, `wb_data=32'h1234` → same cycle `grf_we=1`, `grf_addr=8`, `grf_wd=32'h1234`. With `wb_addr=0` → `grf_we=0`.
- **MD drain:** push (addr 9, data 32'hA5A5) with WB idle → `pend_mask[9]=1` for one cycle. Next cycle `grf_we=1`, `grf_addr=9`. After that edge, `pend_mask=0`.
- **Starvation/full:** DEPTH=2, WB writes every cycle, three MD offers → two accepted, `md_ready=0`, third held. When WB idles, writes drain in order, then the third is accepted.
- **Kill:** queue holds (addr 5, 32'h1). Pipeline writes reg 5 = 32'h2 → `pend_mask[5]` clears. Later cycles show no write of 32'h1 to reg 5. A same-cycle push to 5 is also killed.
- **Address 0 MD:** push with `md_addr=0` → accepted, count unchanged, no write.
- **Reset mid-operation:** two entries queued, assert reset asynchronously → `pend_mask=0` and `grf_we=0` immediately. After release, `md_ready=1` and no stale writes appear.
